// File: rtl/shape_pkg.sv
// Shared constants and encodings for the shape blitter and its row shifter.
package shape_pkg;
    localparam int NUM_ROWS  = 60;
    localparam int ROW_WIDTH = 51;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ORIENT_0     = 2'd0,
        ORIENT_90    = 2'd1,
        ORIENT_180   = 2'd2,
        ORIENT_BLANK = 2'd3
    } orient_t;
endpackage

// File: rtl/shape_blitter_if.sv
// Pixel stream from the blitter to its consumer: valid/ready plus pixel payload.
interface shape_blitter_if;
    logic       valid;
    logic       ready;
    logic       data;
    logic [5:0] x;
    logic [5:0] y;
    logic       last;

    modport master (output valid, data, x, y, last, input ready);
    modport slave  (input valid, data, x, y, last, output ready);
endinterface

// File: rtl/shape_row_shifter.sv
// Row buffer: parallel load from the shape ROM, shift left on enable, MSB is the current pixel.
module shape_row_shifter #(
    parameter int WIDTH = shape_pkg::ROW_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load)
            sr_d = din;
        else if (shift)
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign msb = sr_q[WIDTH-1];
endmodule

// File: rtl/shape_blitter.sv
// Streams a shape bitmap row by row from an external ROM as one pixel per handshake.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_FETCH | rom_address holds the row for the ROM to register
// ST_WAIT  | ROM data valid, loaded into the row shifter
// ST_SHIFT | presenting pixels of the current row
module shape_blitter #(
    parameter int NUM_ROWS  = shape_pkg::NUM_ROWS,
    parameter int ROW_WIDTH = shape_pkg::ROW_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           orientation_in,
    output logic [5:0]           rom_address,
    output logic [1:0]           rom_orientation,
    input  logic [ROW_WIDTH-1:0] rom_data,
    shape_blitter_if.master      pix,
    output logic                 busy,
    output logic                 done
);
    import shape_pkg::*;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [1:0]       orient_q, orient_d;
    logic             done_q, done_d;
    logic             load, shift, hs, msb;

    assign hs = (state_q == ST_SHIFT) && pix.ready;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        orient_d = orient_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    orient_d = orientation_in;
                    row_d    = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                load    = 1'b1;
                col_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (hs) begin
                    shift = 1'b1;
                    if (col_q == LAST_COL) begin
                        if (row_q == LAST_ROW) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any handshake in the same cycle; nothing advances.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            row_d   = row_q;
            col_d   = col_q;
            done_d  = 1'b0;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            orient_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            orient_q <= orient_d;
            done_q   <= done_d;
        end
    end

    shape_row_shifter #(.WIDTH(ROW_WIDTH)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (rom_data),
        .msb   (msb)
    );

    assign pix.valid       = (state_q == ST_SHIFT);
    assign pix.data        = pix.valid & msb;
    assign pix.x           = col_q;
    assign pix.y           = row_q;
    assign pix.last        = pix.valid && (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign rom_address     = row_q;
    assign rom_orientation = orient_q;
endmodule

// File: tb/tb_shape_blitter.sv
// Frame-level bench: synchronous ROM model, expected pixel stream computed from ROM contents.
module tb_shape_blitter;
    localparam int NR   = 60;
    localparam int RW   = 51;
    localparam int NPIX = NR * RW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1:0]    orientation_in;
    logic [5:0]    rom_address;
    logic [1:0]    rom_orientation;
    logic [RW-1:0] rom_data;
    logic          busy;
    logic          done;

    logic [RW-1:0] rom_mem [4][64];

    int errors = 0;
    int checks = 0;

    shape_blitter_if pix();

    shape_blitter #(.NUM_ROWS(NR), .ROW_WIDTH(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .orientation_in  (orientation_in),
        .rom_address     (rom_address),
        .rom_orientation (rom_orientation),
        .rom_data        (rom_data),
        .pix             (pix),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_mem[rom_orientation][rom_address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_valid"}, pix.valid, 0);
        check({pfx, "_data"}, pix.data, 0);
        check({pfx, "_x"}, pix.x, 0);
        check({pfx, "_y"}, pix.y, 0);
        check({pfx, "_last"}, pix.last, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_rom_addr"}, rom_address, 0);
        check({pfx, "_rom_orient"}, rom_orientation, 0);
    endtask

    // mode: 0 ready held, 1 random ready, 2 five-cycle stall at (25,0),
    //       3 restart + orientation change at row 10, 4 reset in row 30, 5 abort in row 5
    task automatic run_frame(input logic [1:0] o, input int mode);
        int k = 0, cyc = 0, first_valid = 0, busy_cyc = 0, done_cnt = 0, stall = 0;
        int ex, ey;
        bit stalled_prev = 0, finished = 0, injected = 0;
        logic ed, el;
        @(negedge clk);
        start = 1'b1;
        orientation_in = o;
        pix.ready = 1'b1;
        while (!finished && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            case (mode)
                1: pix.ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (k == 25 && stall < 5) begin
                        pix.ready = 1'b0;
                        stall++;
                    end else pix.ready = 1'b1;
                end
                default: pix.ready = 1'b1;
            endcase
            if (mode == 3 && !injected && k >= 10 * RW) begin
                start = 1'b1;
                orientation_in = ~o;
                injected = 1;
            end
            if (mode == 4 && k == 30 * RW + 10 && pix.valid) begin
                rst = 1'b1;
                #1;
                check_quiet("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                finished = 1;
                continue;
            end
            if (mode == 5 && k == 5 * RW + 3 && pix.valid) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid", pix.valid, 0);
                check("abort_busy", busy, 0);
                for (int i = 0; i < 4; i++) begin
                    if (done) done_cnt++;
                    @(negedge clk);
                end
                check("abort_no_done", done_cnt, 0);
                finished = 1;
                continue;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                finished = 1;
            end
            if (pix.valid) begin
                if (first_valid == 0) first_valid = cyc;
                if (k < NPIX) begin
                    ex = k % RW;
                    ey = k / RW;
                    ed = rom_mem[o][ey][RW-1-ex];
                    el = (k == NPIX - 1);
                    check("pix_x", pix.x, ex);
                    check("pix_y", pix.y, ey);
                    check("pix_data", pix.data, ed);
                    check("pix_last", pix.last, el);
                end else begin
                    check("overrun_pixels", k, NPIX - 1);
                end
                if (pix.ready) k++;
            end else if (stalled_prev) begin
                check("hold_valid", pix.valid, 1);
            end
            stalled_prev = pix.valid && !pix.ready;
        end
        if (!finished) check("timeout", 0, 1);
        if (mode <= 3) begin
            check("handshakes", k, NPIX);
            check("done_pulses", done_cnt, 1);
            check("first_valid_cycle", first_valid, 3);
            check("rom_orient_kept", rom_orientation, o);
            if (mode == 0 || mode == 3) check("busy_cycles", busy_cyc, 3180);
            if (mode == 2) check("busy_cycles_stall", busy_cyc, 3185);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        logic [63:0] t;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        orientation_in = 2'd0;
        pix.ready = 1'b0;
        for (int o = 0; o < 4; o++)
            for (int r = 0; r < 64; r++) begin
                t = {$urandom, $urandom};
                rom_mem[o][r] = (o == 3) ? '0 : t[RW-1:0];
            end
        rom_mem[0][0] = '0;
        rom_mem[0][0][RW-1-25] = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        run_frame(2'd0, 0);
        run_frame(2'd0, 2);
        run_frame(2'd3, 0);
        run_frame(2'd1, 1);
        run_frame(2'd2, 3);
        run_frame(2'd2, 4);
        run_frame(2'd0, 0);
        run_frame(2'd1, 5);
        run_frame(2'd1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shape_blitter.md
SHAPE_BLITTER -- requirements
Module: shape_blitter

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 60, bitmap rows per shape.
REQ-002 SHALL have parameter ROW_WIDTH, default 51, pixels per bitmap row.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port orientation_in  input  2  shape orientation, latched at start.
REQ-008 SHALL have port rom_address  output  6  row address to shape ROM.
REQ-009 SHALL have port rom_orientation  output  2  orientation to shape ROM.
REQ-010 SHALL have port rom_data  input  ROW_WIDTH  ROM row; valid one cycle after rom_address is registered by the ROM.
REQ-011 SHALL have port pix_valid  output  1  pixel available.
REQ-012 SHALL have port pix_ready  input  1  consumer accepts pixel.
REQ-013 SHALL have port pix_data  output  1  pixel on/off.
REQ-014 SHALL have ports pix_x and pix_y  output  6 each  column and row of the current pixel.
REQ-015 SHALL have port pix_last  output  1  final pixel of frame.
REQ-016 SHALL have ports busy and done  output  1 each  frame in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, SHIFT.
REQ-018 In IDLE with start=1, SHALL latch orientation_in into rom_orientation, clear row to 0, and enter FETCH.
REQ-019 In FETCH, SHALL hold rom_address=row for one cycle, then enter WAIT.
REQ-020 In WAIT, SHALL capture rom_data into the row shift register, clear the column to 0, and enter SHIFT.
REQ-021 In SHIFT, SHALL assert pix_valid and present pix_data=shift-register MSB (column 0 = bit ROW_WIDTH-1), pix_x=column, pix_y=row.
REQ-022 A pixel SHALL be consumed only when pix_valid and pix_ready are both 1. pix_data, pix_x, pix_y and pix_last SHALL remain stable while pix_valid=1 and pix_ready=0.
REQ-023 On a handshake at column ROW_WIDTH-1, SHALL increment row and enter FETCH. When row=NUM_ROWS-1, SHALL instead enter IDLE and pulse done for one cycle.
REQ-024 pix_last SHALL be 1 only at row NUM_ROWS-1, column ROW_WIDTH-1 while pix_valid=1.
REQ-025 The first pix_valid SHALL occur in the third cycle after the edge that accepts start. Each row SHALL incur exactly 2 non-valid cycles (FETCH, WAIT).
REQ-026 busy SHALL be 1 in every state except IDLE. It SHALL fall in the same cycle that done pulses.
REQ-027 start while busy SHALL be ignored. orientation_in changes mid-frame SHALL NOT affect rom_orientation.
REQ-028 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge, with pix_valid=0 and no done pulse. abort SHALL have priority over a simultaneous handshake.
REQ-029 rom_data SHALL be passed through unfiltered. Orientation 3 (ROM returns zero) SHALL still produce a full frame of zero pixels.
REQ-030 Counter widths SHALL be 6 bits. Row and column SHALL never exceed NUM_ROWS-1 and ROW_WIDTH-1.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, with pix_valid=0, busy=0, done=0, pix_last=0, pix_data=0, pix_x=0, pix_y=0, rom_address=0, rom_orientation=0, and the shift register cleared.
REQ-032 Reset mid-frame SHALL abandon the frame. The next start SHALL begin at row 0.

Structure
REQ-033 NUM_ROWS, ROW_WIDTH, the state encoding, and orientation codes 0-3 SHALL reside in shared package shape_pkg.
REQ-034 The load/shift register SHALL be the single sub-module shape_row_shifter (parallel load, shift-on-enable, MSB out). The shape ROM SHALL be instantiated outside this block.

Verification
REQ-035 Start, orientation 0, pix_ready=1 held -> 3060 handshakes; row 0 has its only 1 at x=25; pix_last at (50,59); busy lasts 3180 cycles; done pulses once.
REQ-036 Backpressure: pix_ready=0 for 5 cycles at (25,0) -> pix_valid=1, pix_data=1, pix_x=25, pix_y=0 held throughout; no pixel lost or duplicated.
REQ-037 Orientation 3 -> 3060 zero pixels, then done.
REQ-038 Second start and orientation_in change at row 10 -> ignored; rom_orientation unchanged; frame completes normally.
REQ-039 rst asserted mid-row 30 -> all outputs 0 immediately. abort at row 5 -> IDLE next edge, no done. A subsequent start in either case emits row 0 first.
